// File: rtl/gate_response_checker_pkg.sv
// Shared types and the golden truth table for the gate response checker.
// Bit order of the gate vector: {xnor,xor,nor,nand,buf,not,or,and}.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_BUF  = 3;
    localparam int GATE_NAND = 4;
    localparam int GATE_NOR  = 5;
    localparam int GATE_XOR  = 6;
    localparam int GATE_XNOR = 7;
    localparam int NUM_GATES = 8;

    function automatic logic [NUM_GATES-1:0] golden_gates(
        input logic a,
        input logic b
    );
        logic [NUM_GATES-1:0] g;
        g            = '0;
        g[GATE_AND]  = a & b;
        g[GATE_OR]   = a | b;
        g[GATE_NOT]  = ~a;
        g[GATE_BUF]  = a;
        g[GATE_NAND] = ~(a & b);
        g[GATE_NOR]  = ~(a | b);
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// Bundle between the checker, the gates under test and the controller.
// The checker is the slave; the gate block plus controller form the master.
interface gate_chk_if;
    import gate_chk_pkg::*;

    logic                 start;
    logic [NUM_GATES-1:0] gate_out;
    logic                 vec_a;
    logic                 vec_b;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] err_mask;
    logic [2:0]           err_count;
    logic [1:0]           first_fail_vec;

    modport master (
        output start,
        output gate_out,
        input  vec_a,
        input  vec_b,
        input  busy,
        input  done,
        input  pass,
        input  err_mask,
        input  err_count,
        input  first_fail_vec
    );

    modport slave (
        input  start,
        input  gate_out,
        output vec_a,
        output vec_b,
        output busy,
        output done,
        output pass,
        output err_mask,
        output err_count,
        output first_fail_vec
    );

endinterface

// File: rtl/gate_response_checker_golden.sv
// Combinational expected gate outputs for a 2-bit {a,b} vector.
// Shared by the checker and by any scoreboard that wants the same table.
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic [1:0]           vec,
    output logic [NUM_GATES-1:0] exp
);

    assign exp = golden_gates(vec[1], vec[0]);

endmodule

// File: rtl/gate_response_checker.sv
// Built-in self test for the two-input gate block: walks the four vectors,
// samples the eight outputs and accumulates mismatch results.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    gate_chk_if.slave bus
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t               state;
    state_t               state_n;
    logic [1:0]           vec_idx;
    logic [7:0]           settle_cnt;
    logic                 vec_a;
    logic                 vec_b;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] err_mask;
    logic [2:0]           err_count;
    logic [1:0]           first_fail_vec;
    logic [NUM_GATES-1:0] exp_vec;
    logic [NUM_GATES-1:0] diff;
    logic [NUM_GATES-1:0] mask_n;

    gate_golden_model u_golden (
        .vec (vec_idx),
        .exp (exp_vec)
    );

    assign diff   = bus.gate_out ^ exp_vec;
    assign mask_n = err_mask | diff;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = APPLY;
            APPLY:   state_n = SETTLE;
            SETTLE:  if (settle_cnt == 8'd0) state_n = SAMPLE;
            SAMPLE:  state_n = (vec_idx == 2'd3) ? DONE : APPLY;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vec_idx        <= 2'd0;
            settle_cnt     <= 8'd0;
            vec_a          <= 1'b0;
            vec_b          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_mask       <= '0;
            err_count      <= 3'd0;
            first_fail_vec <= 2'b00;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    vec_a <= 1'b0;
                    vec_b <= 1'b0;
                    if (bus.start) begin
                        err_mask       <= '0;
                        err_count      <= 3'd0;
                        first_fail_vec <= 2'b00;
                        pass           <= 1'b0;
                        vec_idx        <= 2'd0;
                        busy           <= 1'b1;
                    end
                end
                APPLY: begin
                    vec_a      <= vec_idx[1];
                    vec_b      <= vec_idx[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0)
                        settle_cnt <= settle_cnt - 8'd1;
                end
                SAMPLE: begin
                    err_mask <= mask_n;
                    if (diff != '0) begin
                        err_count <= err_count + 3'd1;
                        // err_count still zero means no earlier failure
                        if (err_count == 3'd0)
                            first_fail_vec <= vec_idx;
                    end
                    if (vec_idx == 2'd3) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        pass <= (mask_n == '0);
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                    end
                end
                DONE: begin
                    vec_a <= 1'b0;
                    vec_b <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_a          = vec_a;
    assign bus.vec_b          = vec_b;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_mask       = err_mask;
    assign bus.err_count      = err_count;
    assign bus.first_fail_vec = first_fail_vec;

endmodule
